bcd_to_binary: RTL



---
 rtl/bcd_to_binary_pkg.sv | 40 ++++
 rtl/bcd_to_binary_digit_adjust.sv | 25 ++
 rtl/bcd_to_binary.sv | 134 +++++++++++++
 3 files changed

// File: rtl/bcd_to_binary_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_binary_pkg
// Description : Shared widths, limits and FSM state encoding for the
//               reverse double-dabble BCD-to-binary converter.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_to_binary_pkg;

  // Datapath widths
  localparam int BCD_W       = 12;
  localparam int BIN_W       = 10;
  localparam int OUT_W       = 8;
  localparam int DIGIT_W     = 4;
  localparam int NUM_DIGITS  = 3;
  localparam int CNT_W       = 4;

  // One shift per binary result bit
  localparam int SHIFT_COUNT = 10;
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(SHIFT_COUNT - 1);

  // Largest value representable on the output; also the saturation code
  localparam logic [OUT_W-1:0] SAT_VALUE = 8'hFF;

  // Largest legal BCD digit
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SHIFT  = 2'd1;
  localparam state_t ST_FINISH = 2'd2;

  // True when a 4-bit field does not hold a decimal digit
  function automatic logic digitInvalid(input logic [DIGIT_W-1:0] digit);
    return digit > DIGIT_MAX;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_binary_digit_adjust.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adjust
// Description : Reverse double-dabble digit correction. After a right shift
//               a digit that reads 8 or more subtracts 3 so it stays a valid
//               decimal digit; values >= 8 cannot underflow.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adjust
  import bcd_to_binary_pkg::*;
(
  input  logic [DIGIT_W-1:0] iDigit,
  output logic [DIGIT_W-1:0] oDigit
);

  // Subtract 3 from any digit that reached the 8..15 range
  always_comb begin
    oDigit = iDigit;
    if (iDigit >= 4'd8) begin
      oDigit = iDigit - 4'd3;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_to_binary.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_binary
// Description : Sequential three-digit BCD to 8-bit binary converter with
//               start/done handshake, overflow saturation and digit-error
//               flag. One conversion in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_binary
  import bcd_to_binary_pkg::*;
(
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iStart,
  input  logic [DIGIT_W-1:0] iHundreds,
  input  logic [DIGIT_W-1:0] iTens,
  input  logic [DIGIT_W-1:0] iUnits,
  output logic [OUT_W-1:0]   oBinary,
  output logic               oOverflow,
  output logic               oError,
  output logic               oBusy,
  output logic               oDone
);

  state_t                     r_state;
  logic [BCD_W-1:0]           r_bcd;
  logic [BIN_W-1:0]           r_bin;
  logic [CNT_W-1:0]           r_cnt;
  logic [OUT_W-1:0]           r_binary;
  logic                       r_overflow;
  logic                       r_error;
  logic                       r_busy;
  logic                       r_done;

  logic [BCD_W+BIN_W-1:0]     w_shifted;
  logic [BCD_W-1:0]           w_shiftBcd;
  logic [BIN_W-1:0]           w_shiftBin;
  logic [BCD_W-1:0]           w_adjBcd;
  logic                       w_inputError;

  // Joint right shift: the BCD LSB falls into the binary MSB
  assign w_shifted  = {r_bcd, r_bin} >> 1;
  assign w_shiftBcd = w_shifted[BCD_W+BIN_W-1:BIN_W];
  assign w_shiftBin = w_shifted[BIN_W-1:0];

  // Per-digit correction applied to the freshly shifted BCD
  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit_adjust u_adjust (
        .iDigit (w_shiftBcd[i*DIGIT_W +: DIGIT_W]),
        .oDigit (w_adjBcd[i*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  assign w_inputError = digitInvalid(iHundreds) | digitInvalid(iTens) |
                        digitInvalid(iUnits);

  // Control FSM, datapath and output registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state    <= ST_IDLE;
      r_bcd      <= '0;
      r_bin      <= '0;
      r_cnt      <= '0;
      r_binary   <= '0;
      r_overflow <= 1'b0;
      r_error    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (iStart) begin
            r_bcd  <= {iHundreds, iTens, iUnits};
            r_bin  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (w_inputError) begin
              // Bad digit: report immediately, no shifting
              r_binary   <= '0;
              r_overflow <= 1'b0;
              r_error    <= 1'b1;
              r_done     <= 1'b1;
              r_state    <= ST_FINISH;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end

        ST_SHIFT: begin
          r_bcd <= w_adjBcd;
          r_bin <= w_shiftBin;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LAST_SHIFT) begin
            // Final shift: the binary value is complete in w_shiftBin
            if (w_shiftBin > {2'b00, SAT_VALUE}) begin
              r_binary   <= SAT_VALUE;
              r_overflow <= 1'b1;
            end else begin
              r_binary   <= w_shiftBin[OUT_W-1:0];
              r_overflow <= 1'b0;
            end
            r_error <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FINISH;
          end
        end

        ST_FINISH: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign oBinary   = r_binary;
  assign oOverflow = r_overflow;
  assign oError    = r_error;
  assign oBusy     = r_busy;
  assign oDone     = r_done;

endmodule
`default_nettype wire
